// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue order checker.
package pq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } pq_chk_state_t;

    localparam int          ORDER_ASC    = 0;
    localparam int          ORDER_DESC   = 1;
    localparam logic [15:0] DEF_SENTINEL = 16'hFFFE;

endpackage

// File: rtl/flip_flop.sv
// Enabled register with synchronous active-low reset.
module flip_flop #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst || clr)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/pq_order_checker.sv
// Monitors keys dequeued from a priority queue and flags order violations
// against the previously accepted key, with saturating statistics.
module pq_order_checker
    import pq_pkg::*;
#(
    parameter int          KW       = 16,
    parameter int          CW       = 16,
    parameter int          MODE     = ORDER_ASC,
    parameter logic [KW-1:0] SENTINEL = KW'(DEF_SENTINEL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          empty,
    input  logic          clear,
    input  logic [KW-1:0] din,
    output logic          verdict,
    output logic          sentinel_hit,
    output logic          sticky_err,
    output logic [CW-1:0] viol_count,
    output logic [CW-1:0] sample_count,
    output logic [CW-1:0] first_viol_idx,
    output logic          tracking
);

    pq_chk_state_t state_q, state_d;
    logic [KW-1:0] ref_q;
    logic          accept, viol, sent;
    logic [CW-1:0] sc_post;
    logic          verdict_q, verdict_d, sent_q, sent_d, sticky_q, sticky_d;
    logic [CW-1:0] fvi_q, fvi_d;

    assign accept = enb & ~empty;

    // din only enters the comparators behind accept so X keys stay contained
    always_comb begin
        viol = 1'b0;
        sent = 1'b0;
        if (accept) begin
            sent = (din == SENTINEL);
            if (state_q == TRACK)
                viol = (MODE == ORDER_DESC) ? (din > ref_q) : (din < ref_q);
        end
    end

    assign sc_post = (&sample_count) ? sample_count : sample_count + 1'b1;

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (accept) state_d = TRACK;
                TRACK:   if (empty)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        verdict_d = viol;
        sent_d    = sent;
        sticky_d  = sticky_q;
        fvi_d     = fvi_q;
        if (clear) begin
            verdict_d = 1'b0;
            sent_d    = 1'b0;
            sticky_d  = 1'b0;
            fvi_d     = '0;
        end else if (viol && !sticky_q) begin
            sticky_d = 1'b1;
            fvi_d    = sc_post;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            verdict_q <= 1'b0;
            sent_q    <= 1'b0;
            sticky_q  <= 1'b0;
            fvi_q     <= '0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
            sent_q    <= sent_d;
            sticky_q  <= sticky_d;
            fvi_q     <= fvi_d;
        end
    end

    // Reference advances on every accepted key, violating or not
    flip_flop #(.W(KW)) u_ref (
        .clk (clk),
        .rst (rst),
        .en  (accept | clear),
        .d   (clear ? '0 : din),
        .q   (ref_q)
    );

    sat_counter #(.CW(CW)) u_viol_cnt (
        .clk (clk),
        .rst (rst),
        .inc (viol),
        .clr (clear),
        .q   (viol_count)
    );

    sat_counter #(.CW(CW)) u_sample_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept),
        .clr (clear),
        .q   (sample_count)
    );

    assign verdict        = verdict_q;
    assign sentinel_hit   = sent_q;
    assign sticky_err     = sticky_q;
    assign first_viol_idx = fvi_q;
    assign tracking       = (state_q == TRACK);

endmodule
